// File: rtl/fb_pkg.sv
// Shared types and constants for the frame buffer write path.
// Entries carry a 20-bit linear address and one RGB888 pixel.
package fb_pkg;

    localparam int FB_ADDR_W       = 20;
    localparam int FB_PIX_W        = 24;
    localparam int FB_FRAME_PIXELS = 307200;

    typedef enum logic {
        WAIT_SOF,
        ACTIVE
    } fbw_state_t;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_PIX_W-1:0]  data;
    } fb_entry_t;

    // Advance a frame pointer, wrapping after the last pixel.
    function automatic logic [FB_ADDR_W-1:0] fb_ptr_inc(
        input logic [FB_ADDR_W-1:0] p,
        input logic [FB_ADDR_W-1:0] last
    );
        if (p == last) begin
            return '0;
        end
        return p + FB_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/fbw_fifo.sv
// Two-entry {addr,data} queue between pixel intake and the SRAM port.
// The head stays in place until popped, so it can be presented to memory.
module fbw_fifo
    import fb_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_clr,
    input  logic      i_push,
    input  fb_entry_t i_din,
    input  logic      i_pop,
    output fb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    fb_entry_t  r_mem [2];
    logic       r_wp;
    logic       r_rp;
    logic [1:0] r_cnt;
    logic       w_push_ok;
    logic       w_pop_ok;

    assign o_full    = (r_cnt == 2'd2);
    assign o_empty   = (r_cnt == 2'd0);
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_head    = r_mem[r_rp];

    // Storage, pointers and occupancy; a full queue may push if it pops too.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
        end else if (i_clr) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wp] <= i_din;
                r_wp        <= ~r_wp;
            end
            if (w_pop_ok) begin
                r_rp <= ~r_rp;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_cnt <= r_cnt + 2'd1;
            end else if (!w_push_ok && w_pop_ok) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

endmodule

// File: rtl/framebuffer_writer.sv
// Pixel stream to frame buffer SRAM writer with self-generated addresses.
// Optional FBW_FRAME_CNT_EN adds an 8-bit completed-frame counter output.
module framebuffer_writer
    import fb_pkg::*;
#(
    parameter int FRAME_PIXELS = FB_FRAME_PIXELS,
    parameter int PIX_W        = FB_PIX_W
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_rst,
    input  logic                 enable,
    input  logic                 pix_valid,
    input  logic                 pix_sof,
    input  logic [PIX_W-1:0]     pix_data,
    output logic                 pix_ready,
    output logic                 mem_req,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]     mem_wdata,
    input  logic                 mem_ack,
    output logic                 frame_done,
    output logic                 sync_err
`ifdef FBW_FRAME_CNT_EN
    ,
    output logic [7:0]           frame_count
`endif
);

    localparam logic [FB_ADDR_W-1:0] LAST_ADDR =
        FB_ADDR_W'(FRAME_PIXELS - 1);

    fbw_state_t           r_state;
    fbw_state_t           w_state_nxt;
    logic [FB_ADDR_W-1:0] r_wr_ptr;
    logic [FB_ADDR_W-1:0] w_wr_ptr_nxt;
    logic                 w_ready;
    logic                 w_push;
    fb_entry_t            w_entry;
    logic                 w_sync_err;
    logic                 r_sync_err;
    logic                 w_pop;
    fb_entry_t            w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 r_req;
    logic [FB_ADDR_W-1:0] r_addr;
    logic [PIX_W-1:0]     r_wdata;
    logic                 r_frame_done;

    fbw_fifo u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (s_rst),
        .i_push  (w_push),
        .i_din   (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State, write pointer and sync-error pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= WAIT_SOF;
            r_wr_ptr   <= '0;
            r_sync_err <= 1'b0;
        end else if (s_rst) begin
            r_state    <= WAIT_SOF;
            r_wr_ptr   <= '0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_sync_err <= w_sync_err;
        end
    end

    // Intake: handshake, address assignment and frame (re)alignment.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_ready      = 1'b0;
        w_push       = 1'b0;
        w_entry      = '0;
        w_sync_err   = 1'b0;
        unique case (r_state)
            WAIT_SOF: begin
                w_ready = enable;
                if (pix_valid && w_ready && pix_sof) begin
                    w_push       = 1'b1;
                    w_entry.data = pix_data;
                    w_wr_ptr_nxt = fb_ptr_inc('0, LAST_ADDR);
                    w_state_nxt  = ACTIVE;
                end
            end
            ACTIVE: begin
                w_ready = enable & ~w_full;
                if (pix_valid && w_ready) begin
                    w_push       = 1'b1;
                    w_entry.data = pix_data;
                    if (pix_sof) begin
                        w_sync_err   = (r_wr_ptr != '0);
                        w_wr_ptr_nxt = fb_ptr_inc('0, LAST_ADDR);
                    end else begin
                        w_entry.addr = r_wr_ptr;
                        w_wr_ptr_nxt = fb_ptr_inc(r_wr_ptr, LAST_ADDR);
                    end
                end
            end
        endcase
    end

    assign w_pop = r_req & mem_ack;

    // Memory port: load the head while idle, drop request and pop on ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_frame_done <= 1'b0;
        end else if (s_rst) begin
            r_req        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_req) begin
                if (mem_ack) begin
                    r_req        <= 1'b0;
                    r_frame_done <= (r_addr == LAST_ADDR);
                end
            end else if (!w_empty) begin
                r_req   <= 1'b1;
                r_addr  <= w_head.addr;
                r_wdata <= w_head.data;
            end
        end
    end

    assign pix_ready  = w_ready;
    assign mem_req    = r_req;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;

`ifdef FBW_FRAME_CNT_EN
    logic [7:0] r_frame_count;

    // Completed-frame counter; a resync restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_count <= 8'd0;
        end else if (s_rst) begin
            r_frame_count <= 8'd0;
        end else if (r_sync_err) begin
            r_frame_count <= 8'd0;
        end else if (r_frame_done) begin
            r_frame_count <= r_frame_count + 8'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_framebuffer_writer.sv
// Bench for framebuffer_writer: queue-based write model plus directed cases.
// Build with FBW_FRAME_CNT_EN defined to also cover frame_count.
module tb_framebuffer_writer;
    import fb_pkg::*;

    localparam int FP = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_rst = 1'b0;
    logic        enable = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic [23:0] pix_data = '0;
    logic        mem_ack = 1'b0;
    logic        pix_ready;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic [23:0] mem_wdata;
    logic        frame_done;
    logic        sync_err;
`ifdef FBW_FRAME_CNT_EN
    logic [7:0]  frame_count;
`endif

    framebuffer_writer #(.FRAME_PIXELS(FP), .PIX_W(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_rst      (s_rst),
        .enable     (enable),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .frame_done (frame_done),
        .sync_err   (sync_err)
`ifdef FBW_FRAME_CNT_EN
        ,
        .frame_count(frame_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // SRAM responder: ack after ack_delay waiting cycles; optional stray acks.
    int ack_delay = 0;
    bit stray = 1'b0;
    int wcnt = 0;
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            if (wcnt >= ack_delay) begin
                mem_ack = 1'b1;
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = stray;
            wcnt = 0;
        end
    end

    // Model: outstanding writes as a queue, frame position as an integer.
    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t q[$];
    bit  in_frame = 1'b0;
    int  ptr = 0;
    bit  req_m = 1'b0;
    bit  fd_m = 1'b0;
    bit  se_m = 1'b0;
    int  fc_m = 0;

    function automatic bit exp_ready();
        return enable && (!in_frame || q.size() < 2);
    endfunction

    always @(posedge clk) begin
        bit xfer;
        bit fd_n;
        bit se_n;
        if (rst || s_rst) begin
            q.delete();
            in_frame = 1'b0;
            ptr = 0;
            req_m = 1'b0;
            fd_m = 1'b0;
            se_m = 1'b0;
            fc_m = 0;
        end else begin
            xfer = pix_valid && exp_ready();
            if (se_m) fc_m = 0;
            else if (fd_m) fc_m = (fc_m + 1) % 256;
            fd_n = 1'b0;
            se_n = 1'b0;
            if (req_m) begin
                if (mem_ack) begin
                    fd_n = (q[0].addr == FP - 1);
                    void'(q.pop_front());
                    req_m = 1'b0;
                end
            end else if (q.size() > 0) begin
                req_m = 1'b1;
            end
            if (xfer) begin
                if (pix_sof) begin
                    se_n = in_frame && (ptr != 0);
                    q.push_back('{0, int'(pix_data)});
                    ptr = 1 % FP;
                    in_frame = 1'b1;
                end else if (in_frame) begin
                    q.push_back('{ptr, int'(pix_data)});
                    ptr = (ptr + 1) % FP;
                end
            end
            fd_m = fd_n;
            se_m = se_n;
        end
    end

    // Cycle compare against the model, plus pulse counts and a write log.
    int  fd_cnt = 0;
    int  se_cnt = 0;
    wr_t wlog[$];

    always @(negedge clk) begin
        if (!rst) begin
            chk("pix_ready", 64'(pix_ready), 64'(exp_ready()));
            chk("mem_req", 64'(mem_req), 64'(req_m));
            if (req_m && q.size() > 0) begin
                chk("mem_addr", 64'(mem_addr), 64'(q[0].addr));
                chk("mem_wdata", 64'(mem_wdata), 64'(q[0].data));
            end
            chk("frame_done", 64'(frame_done), 64'(fd_m));
            chk("sync_err", 64'(sync_err), 64'(se_m));
`ifdef FBW_FRAME_CNT_EN
            chk("frame_count", 64'(frame_count), 64'(fc_m));
`endif
            if (frame_done) fd_cnt++;
            if (sync_err) se_cnt++;
            if (mem_req && mem_ack) begin
                wlog.push_back('{int'(mem_addr), int'(mem_wdata)});
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [23:0] d, input bit sof);
        bit r;
        int t;
        t = 0;
        pix_valid = 1'b1;
        pix_data = d;
        pix_sof = sof;
        do begin
            @(negedge clk);
            r = pix_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!r && t < 200);
        chk("send_accept", 64'(r), 64'd1);
        pix_valid = 1'b0;
        pix_sof = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() > 0 || req_m) && t < 300) begin
            cycles(1);
            t++;
        end
        chk("drain_in_time", 64'(t < 300), 64'd1);
        cycles(3);
    endtask

    task automatic do_srst();
        s_rst = 1'b1;
        cycles(1);
        s_rst = 1'b0;
        wlog.delete();
        fd_cnt = 0;
        se_cnt = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_fd", 64'(frame_done), 64'd0);
        chk("rst_se", 64'(sync_err), 64'd0);
        cycles(1);

        // 1: non-sof pixels dropped, then a frame start at address 0
        enable = 1'b1;
        ack_delay = 1;
        send(24'h000011, 1'b0);
        send(24'h000012, 1'b0);
        send(24'h000013, 1'b0);
        send(24'hAA0000, 1'b1);
        @(negedge clk);
        chk("t1_lat_n", 64'(mem_req), 64'd0);
        @(negedge clk);
        chk("t1_lat_req", 64'(mem_req), 64'd1);
        chk("t1_lat_addr", 64'(mem_addr), 64'd0);
        chk("t1_lat_data", 64'(mem_wdata), 64'hAA0000);
        cycles(1);
        send(24'hAA0001, 1'b0);
        send(24'hAA0002, 1'b0);
        drain();
        chk("t1_nwr", 64'(wlog.size()), 64'd3);
        for (int i = 0; i < 3 && i < wlog.size(); i++) begin
            chk("t1_addr", 64'(wlog[i].addr), 64'(i));
            chk("t1_data", 64'(wlog[i].data), 64'(32'hAA0000 + i));
        end
        chk("t1_no_se", 64'(se_cnt), 64'd0);

        // 2: two full frames, enable pause mid-frame, stray acks
        do_srst();
        ack_delay = 0;
        stray = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                enable = 1'b0;
                cycles(5);
                enable = 1'b1;
            end
            send(24'hB00000 | 24'(i), (i % 8) == 0);
        end
        drain();
        stray = 1'b0;
        chk("t2_fd_cnt", 64'(fd_cnt), 64'd2);
        chk("t2_nwr", 64'(wlog.size()), 64'd16);
        for (int i = 0; i < 16 && i < wlog.size(); i++) begin
            chk("t2_addr", 64'(wlog[i].addr), 64'(i % 8));
            chk("t2_data", 64'(wlog[i].data), 64'(32'hB00000 + i));
        end
`ifdef FBW_FRAME_CNT_EN
        chk("t2_fcount", 64'(frame_count), 64'd2);
`endif

        // 3: memory stalls; request held, intake backs up at 2 entries
        do_srst();
        ack_delay = 10;
        send(24'hC00000, 1'b1);
        send(24'hC00001, 1'b0);
        @(negedge clk);
        chk("t3_full_rdy", 64'(pix_ready), 64'd0);
        chk("t3_hold_req", 64'(mem_req), 64'd1);
        chk("t3_hold_addr", 64'(mem_addr), 64'd0);
        chk("t3_hold_data", 64'(mem_wdata), 64'hC00000);
        cycles(1);
        send(24'hC00002, 1'b0);
        send(24'hC00003, 1'b0);
        drain();
        chk("t3_nwr", 64'(wlog.size()), 64'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            chk("t3_addr", 64'(wlog[i].addr), 64'(i));
            chk("t3_data", 64'(wlog[i].data), 64'(32'hC00000 + i));
        end

        // 4: sof arrives at position 5 with 3 and 4 still queued
        do_srst();
        ack_delay = 0;
        send(24'hD00000, 1'b1);
        send(24'hD00001, 1'b0);
        send(24'hD00002, 1'b0);
        ack_delay = 8;
        send(24'hD00003, 1'b0);
        send(24'hD00004, 1'b0);
        send(24'hDD0000, 1'b1);
        send(24'hDD0001, 1'b0);
        drain();
        chk("t4_se_cnt", 64'(se_cnt), 64'd1);
        chk("t4_nwr", 64'(wlog.size()), 64'd7);
        if (wlog.size() == 7) begin
            chk("t4_a3", 64'(wlog[3].addr), 64'd3);
            chk("t4_a4", 64'(wlog[4].addr), 64'd4);
            chk("t4_sof_a", 64'(wlog[5].addr), 64'd0);
            chk("t4_sof_d", 64'(wlog[5].data), 64'hDD0000);
            chk("t4_next_a", 64'(wlog[6].addr), 64'd1);
        end
`ifdef FBW_FRAME_CNT_EN
        chk("t4_fcount", 64'(frame_count), 64'd0);
`endif

        // 5: synchronous restart with a request outstanding
        ack_delay = 100;
        send(24'hE00000, 1'b0);
        cycles(1);
        @(negedge clk);
        chk("t5_pre_req", 64'(mem_req), 64'd1);
        cycles(1);
        do_srst();
        @(negedge clk);
        chk("t5_req", 64'(mem_req), 64'd0);
        chk("t5_addr", 64'(mem_addr), 64'd0);
        chk("t5_data", 64'(mem_wdata), 64'd0);
        cycles(1);
        ack_delay = 0;
        send(24'hE00001, 1'b0);
        send(24'hE00002, 1'b0);
        cycles(5);
        chk("t5_nwr", 64'(wlog.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
